// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined mux tree.
//   clog2            : ceiling log2, used to size the select and tree depth
//   MUX_MAX_NUM_IN   : largest channel count the tree is intended for
//   MUX_STAGE_T      : macro for the handshake stage struct of one pipeline
//                      level (valid, data, remaining select bits, error flag)
// Optional feature macro used by the top: MUX_SEL_CHECK_EN.
`define MUX_STAGE_T(DW, SW) struct packed { logic valid; logic [(DW)-1:0] data; logic [(SW)-1:0] sel_rem; logic err; }

package mux_pkg;

  localparam int MUX_MAX_NUM_IN = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_2x1_reg.sv
// Registered 2:1 node of the mux tree.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears the stored word
//   en   : load enable (a valid transfer into this node's stage)
//   sel  : 0 selects in0, 1 selects in1
//   in0  : even child word
//   in1  : odd child word
//   out  : registered selected word, held while en is low
module mux_2x1_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  always_comb begin
    out_d = out_q;
    if (en) out_d = sel ? in1 : in0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer: a binary tree of registered 2:1 nodes, one tree
// level per pipeline stage, with a valid/ready handshake per stage. Latency is
// clog2(NUM_IN) cycles and throughput is one word per cycle.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   in_data    : NUM_IN channels, channel i at [i*WIDTH +: WIDTH]
//   in_sel     : channel to forward, sampled together with in_data
//   in_valid   : input word valid; transfer when in_valid & in_ready
//   in_ready   : stage 0 can accept (combinational from out_ready)
//   out_data   : selected word
//   out_valid  : out_data valid; transfer when out_valid & out_ready
//   out_ready  : sink accepts
//   sel_err    : present only when MUX_SEL_CHECK_EN is defined; high with
//                out_valid when the word was selected with in_sel >= NUM_IN
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = clog2(NUM_IN),
  localparam int LEVELS = SEL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_SEL_CHECK_EN
  ,
  output logic                    sel_err
`endif
);

  localparam int LEAVES = 2 ** LEVELS;
  localparam int TOT_W  = 2 * LEAVES - 1;
  localparam int SR_W   = SEL_W * (SEL_W - 1) / 2;

  // Word offset of tree level m inside tree_w: level 0 is the padded leaves,
  // level m (m >= 1) is the output of pipeline stage m-1, the root is last.
  function automatic int lvl_off(input int m);
    return 2 * LEAVES - ((2 * LEAVES) >> m);
  endfunction

  // Stage k keeps the select bits [SEL_W-1:k+1]; these bit fields are packed
  // back to back, so stage k's field starts at this offset.
  function automatic int sel_off(input int k);
    return k * (SEL_W - 1) - (k * (k - 1)) / 2;
  endfunction

  logic [TOT_W*WIDTH-1:0] tree_w;
  logic [LEVELS-1:0]      rdy;
  logic [LEVELS:0]        vld_chain;
  logic [LEVELS-1:0]      vld_d;
  logic [LEVELS-1:0]      vld_q;
  logic [LEVELS-1:0]      node_en;
  logic [LEVELS-1:0]      node_sel;

  assign vld_chain = {vld_q, in_valid};

  // A stage can load when it is empty or everything downstream can move;
  // unrolled so each ready depends only on valid flops and out_ready.
  genvar k, j, i;
  for (k = 0; k < LEVELS; k++) begin : g_rdy
    assign rdy[k] = out_ready | ~(&vld_q[LEVELS-1:k]);
  end

  always_comb begin
    for (int s = 0; s < LEVELS; s++) begin
      node_en[s] = rdy[s] & vld_chain[s];
      vld_d[s]   = rdy[s] ? vld_chain[s] : vld_q[s];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  // Leaves beyond NUM_IN read as zero so out-of-range selects give 0.
  for (i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < NUM_IN) begin : g_in
      assign tree_w[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign tree_w[i*WIDTH +: WIDTH] = '0;
    end
  end

  // Pipeline stage k: node j picks between words 2j and 2j+1 of level k.
  for (k = 0; k < LEVELS; k++) begin : g_lvl
    for (j = 0; j < (LEAVES >> (k + 1)); j++) begin : g_node
      mux_2x1_reg #(
        .WIDTH (WIDTH)
      ) u_node (
        .clk (clk),
        .rst (rst),
        .en  (node_en[k]),
        .sel (node_sel[k]),
        .in0 (tree_w[(lvl_off(k) + 2*j) * WIDTH +: WIDTH]),
        .in1 (tree_w[(lvl_off(k) + 2*j + 1) * WIDTH +: WIDTH]),
        .out (tree_w[(lvl_off(k + 1) + j) * WIDTH +: WIDTH])
      );
    end
  end

  assign out_data  = tree_w[(TOT_W - 1) * WIDTH +: WIDTH];
  assign out_valid = vld_chain[LEVELS];
  assign in_ready  = rdy[0];

  // Select bit k travels with the word until stage k consumes it.
  assign node_sel[0] = in_sel[0];
  if (SEL_W > 1) begin : g_sel
    logic [SR_W-1:0] sel_d;
    logic [SR_W-1:0] sel_q;
    for (k = 0; k < LEVELS - 1; k++) begin : g_st
      localparam int SW_K = SEL_W - 1 - k;
      logic [SW_K-1:0] sel_in;
      if (k == 0) begin : g_first
        assign sel_in = in_sel[SEL_W-1:1];
      end else begin : g_next
        assign sel_in = sel_q[sel_off(k - 1) + 1 +: SW_K];
      end
      assign sel_d[sel_off(k) +: SW_K] = node_en[k] ? sel_in : sel_q[sel_off(k) +: SW_K];
      assign node_sel[k + 1] = sel_q[sel_off(k)];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) sel_q <= '0;
      else     sel_q <= sel_d;
    end
  end

`ifdef MUX_SEL_CHECK_EN
  logic [LEVELS:0]   err_chain;
  logic [LEVELS-1:0] err_d;
  logic [LEVELS-1:0] err_q;
  logic              sel_oor;

  // With a full power-of-two tree every select code is a real channel.
  if (NUM_IN == LEAVES) begin : g_pow2
    assign sel_oor = 1'b0;
  end else begin : g_chk
    assign sel_oor = (in_sel >= SEL_W'(NUM_IN));
  end

  assign err_chain = {err_q, sel_oor};

  always_comb begin
    for (int s = 0; s < LEVELS; s++) begin
      err_d[s] = node_en[s] ? err_chain[s] : err_q[s];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign sel_err = err_chain[LEVELS] & out_valid;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
module tb_mux_tree_pipe;

  localparam int NCFG   = 5;
  localparam int NTX    = 10000;
  localparam int BUDGET = 40000;

  function automatic int cfg_n(input int g);
    case (g)
      0: return 2;
      1: return 3;
      2: return 8;
      3: return 13;
      default: return 5;
    endcase
  endfunction

  function automatic int cfg_w(input int g);
    return (g == 4) ? 16 : 8;
  endfunction

  logic clk;
  logic rst_a;
  logic rst_r;
  int   errors;
  int   checks;
  bit   done_r [NCFG];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  // Directed instance: 4 channels of 8 bits
  logic [31:0] in_data_a;
  logic [1:0]  in_sel_a;
  logic        in_valid_a;
  logic        in_ready_a;
  logic [7:0]  out_data_a;
  logic        out_valid_a;
  logic        out_ready_a;
  logic [7:0]  qa [$];
`ifdef MUX_SEL_CHECK_EN
  logic        sel_err_a;
`endif

  mux_tree_pipe #(.WIDTH(8), .NUM_IN(4)) u_dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .in_data   (in_data_a),
    .in_sel    (in_sel_a),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .out_data  (out_data_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a)
`ifdef MUX_SEL_CHECK_EN
    ,
    .sel_err   (sel_err_a)
`endif
  );

  // One cycle of the directed instance: record an accepted word in the
  // scoreboard, then return just after the next rising edge.
  task automatic cyc_a();
    @(negedge clk);
    if (in_valid_a && in_ready_a) qa.push_back(in_data_a[int'(in_sel_a)*8 +: 8]);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [7:0] ea;
    if (out_valid_a && out_ready_a) begin
      if (qa.size() == 0) check(1'b0, "a_unexpected_out", 64'(out_data_a), 64'd0);
      else begin
        ea = qa.pop_front();
        check(out_data_a === ea, "a_data", 64'(out_data_a), 64'(ea));
      end
    end
`ifdef MUX_SEL_CHECK_EN
    check(sel_err_a === 1'b0, "a_sel_err", 64'(sel_err_a), 64'd0);
`endif
  end

  // Randomised instances, one per channel-count configuration
  for (genvar g = 0; g < NCFG; g++) begin : g_rnd
    localparam int N  = cfg_n(g);
    localparam int W  = cfg_w(g);
    localparam int SW = $clog2(N);
    logic [N*W-1:0] din;
    logic [SW-1:0]  dsel;
    logic           dvld;
    logic           drdy;
    logic [W-1:0]   odata;
    logic           ovld;
    logic           ordy;
    logic [W-1:0]   qd [$];
    bit             qe [$];
`ifdef MUX_SEL_CHECK_EN
    logic           serr;
`endif

    mux_tree_pipe #(.WIDTH(W), .NUM_IN(N)) u_dut (
      .clk       (clk),
      .rst       (rst_r),
      .in_data   (din),
      .in_sel    (dsel),
      .in_valid  (dvld),
      .in_ready  (drdy),
      .out_data  (odata),
      .out_valid (ovld),
      .out_ready (ordy)
`ifdef MUX_SEL_CHECK_EN
      ,
      .sel_err   (serr)
`endif
    );

    initial begin
      int sent;
      int cyc;
      int s;
      bit acc;
      bit first;
      logic [W-1:0] e;
      sent  = 0;
      cyc   = 0;
      acc   = 1'b0;
      first = 1'b1;
      dvld  = 1'b0;
      ordy  = 1'b0;
      din   = '0;
      dsel  = '0;
      repeat (5) @(posedge clk);
      #1;
      while (sent < NTX && cyc < BUDGET) begin
        if (!dvld || acc) begin
          dvld = ($urandom_range(0, 9) < 7);
          for (int c = 0; c < N; c++) din[c*W +: W] = W'($urandom);
          if (first && dvld) begin
            // first word exercises the padded leaf where one exists
            dsel  = SW'((N < 2**SW) ? N : N - 1);
            first = 1'b0;
          end else begin
            dsel = SW'($urandom_range(0, 2**SW - 1));
          end
        end
        ordy = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        acc = dvld && drdy;
        if (acc) begin
          s = int'(dsel);
          e = '0;
          if (s < N) e = din[s*W +: W];
          qd.push_back(e);
          qe.push_back(s >= N);
          sent++;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      dvld = 1'b0;
      ordy = 1'b1;
      for (int t = 0; t < 40 && qd.size() != 0; t++) @(posedge clk);
      #1;
      check(sent == NTX, "rnd_sent", 64'(sent), 64'(NTX));
      check(qd.size() == 0, "rnd_drained", 64'(qd.size()), 64'd0);
      done_r[g] = 1'b1;
    end

    always @(negedge clk) begin
      logic [W-1:0] ed;
      bit ee;
      if (ovld && ordy) begin
        if (qd.size() == 0) check(1'b0, "rnd_unexpected_out", 64'(odata), 64'd0);
        else begin
          ed = qd.pop_front();
          ee = qe.pop_front();
          check(odata === ed, "rnd_data", 64'(odata), 64'(ed));
`ifdef MUX_SEL_CHECK_EN
          check(serr === ee, "rnd_sel_err", 64'(serr), 64'(ee));
`else
          check(!ee || odata === '0, "rnd_oor_zero", 64'(odata), 64'd0);
`endif
        end
      end
    end
  end

  function automatic bit all_done();
    for (int g = 0; g < NCFG; g++) if (!done_r[g]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    logic [7:0] hold;
    errors      = 0;
    checks      = 0;
    rst_a       = 1'b1;
    rst_r       = 1'b1;
    in_data_a   = 32'h44332211;
    in_sel_a    = 2'd0;
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(out_valid_a === 1'b0, "rst_out_valid", 64'(out_valid_a), 64'd0);
    check(out_data_a === 8'h00, "rst_out_data", 64'(out_data_a), 64'd0);
    rst_a = 1'b0;
    rst_r = 1'b0;
    #1;
    check(in_ready_a === 1'b1, "rst_in_ready", 64'(in_ready_a), 64'd1);

    // single word, sel=2, two-cycle latency
    in_valid_a = 1'b1;
    in_sel_a   = 2'd2;
    cyc_a();
    in_valid_a = 1'b0;
    check(out_valid_a === 1'b0, "t1_not_yet", 64'(out_valid_a), 64'd0);
    cyc_a();
    check(out_valid_a === 1'b1, "t1_latency", 64'(out_valid_a), 64'd1);
    check(out_data_a === 8'h33, "t1_data", 64'(out_data_a), 64'h33);
    cyc_a();
    check(out_valid_a === 1'b0, "t1_gone", 64'(out_valid_a), 64'd0);

    // back-to-back stream sel=0..3
    in_valid_a = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_sel_a = 2'(s);
      check(in_ready_a === 1'b1, "t2_in_ready", 64'(in_ready_a), 64'd1);
      cyc_a();
      if (s >= 1) begin
        check(out_valid_a === 1'b1, "t2_valid", 64'(out_valid_a), 64'd1);
        check(out_data_a === 8'(8'h11 * s), "t2_data", 64'(out_data_a), 64'(8'h11 * s));
      end
    end
    in_valid_a = 1'b0;
    cyc_a();
    check(out_data_a === 8'h44, "t2_last", 64'(out_data_a), 64'h44);
    cyc_a();
    check(out_valid_a === 1'b0, "t2_end", 64'(out_valid_a), 64'd0);

    // fill with the output stalled, hold for 5 cycles, then drain
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1;
    in_sel_a    = 2'd3;
    cyc_a();
    check(in_ready_a === 1'b1, "t3_bubble_ready", 64'(in_ready_a), 64'd1);
    in_sel_a = 2'd1;
    cyc_a();
    check(in_ready_a === 1'b0, "t3_full", 64'(in_ready_a), 64'd0);
    hold = out_data_a;
    check(hold === 8'h44, "t3_head", 64'(hold), 64'h44);
    in_sel_a = 2'd0;
    repeat (5) begin
      cyc_a();
      check(out_valid_a === 1'b1 && out_data_a === hold, "t3_hold", 64'(out_data_a), 64'(hold));
      check(in_ready_a === 1'b0, "t3_stall_ready", 64'(in_ready_a), 64'd0);
    end
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    repeat (4) cyc_a();
    check(qa.size() == 0, "t3_no_loss", 64'(qa.size()), 64'd0);

    // reset with two words in flight
    in_valid_a = 1'b1;
    in_sel_a   = 2'd0;
    cyc_a();
    in_sel_a = 2'd1;
    cyc_a();
    rst_a      = 1'b1;
    in_valid_a = 1'b0;
    qa.delete();
    #1;
    check(out_valid_a === 1'b0, "t5_flush", 64'(out_valid_a), 64'd0);
    repeat (2) cyc_a();
    rst_a = 1'b0;
    #1;
    check(in_ready_a === 1'b1, "t5_in_ready", 64'(in_ready_a), 64'd1);
    repeat (4) begin
      cyc_a();
      check(out_valid_a === 1'b0, "t5_quiet", 64'(out_valid_a), 64'd0);
    end
    in_valid_a = 1'b1;
    in_sel_a   = 2'd2;
    cyc_a();
    in_valid_a = 1'b0;
    repeat (4) cyc_a();
    check(qa.size() == 0, "t5_new_word", 64'(qa.size()), 64'd0);

    for (int t = 0; t < 50000; t++) begin
      if (all_done()) break;
      @(posedge clk);
    end
    check(all_done(), "timeout", 64'(all_done()), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
